// File: rtl/aes_pkg.sv
// aes_pkg: shared AES forward/inverse S-box tables and byte-lane width.
package aes_pkg;
   localparam int BYTE_W = 8;
   typedef logic [BYTE_W-1:0] byte_t;
   localparam byte_t SBOX_FWD [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };
   localparam byte_t SBOX_INV [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };
endpackage

// File: rtl/sbox_byte.sv
// sbox_byte: combinational single-byte AES forward/inverse substitution.
module sbox_byte
   import aes_pkg::*;
(
   input  logic  mode_i,
   input  byte_t d_i,
   output byte_t q_o
);
   assign q_o = mode_i ? SBOX_INV[d_i] : SBOX_FWD[d_i];
endmodule

// File: rtl/sbox_lanes.sv
// sbox_lanes: multi-lane AES S-box with a PIPE-deep valid/ready pipeline.
module sbox_lanes
   import aes_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int PIPE   = 2,
   parameter int INV_EN = 1
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_mode,
   input  logic [8*LANES-1:0]    in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*LANES-1:0]    out_data,
   output logic                  out_mode,
   output logic [15:0]           xfer_cnt
);
   localparam int W = LANES * BYTE_W;
   logic                   mode_in;
   logic [W-1:0]           sub;
   logic [PIPE-1:0]        vld_q, vld_d, mode_q, mode_d, ld;
   logic [PIPE-1:0][W-1:0] data_q, data_d;
   logic [PIPE:0]          vsrc, msrc;
   logic [PIPE:0][W-1:0]   dsrc;
   logic [15:0]            cnt_q, cnt_d;
   assign mode_in = (INV_EN != 0) && in_mode;
   genvar i;
   for (i = 0; i < LANES; i++) begin : g_lane
      sbox_byte u_sbox (
         .mode_i (mode_in),
         .d_i    (in_data[BYTE_W*i +: BYTE_W]),
         .q_o    (sub[BYTE_W*i +: BYTE_W])
      );
   end
   // index 0 of each source vector is the pipeline input, index k feeds stage k
   assign vsrc = {vld_q, in_valid};
   assign msrc = {mode_q, mode_in};
   assign dsrc = {data_q, sub};
   // a stage can load if the output drains or any stage from it onward is empty
   always_comb begin
      for (int k = 0; k < PIPE; k++) begin
         ld[k] = out_ready;
         for (int j = k; j < PIPE; j++) ld[k] = ld[k] | ~vld_q[j];
         vld_d[k]  = ld[k] ? vsrc[k] : vld_q[k];
         mode_d[k] = (ld[k] && vsrc[k]) ? msrc[k] : mode_q[k];
         data_d[k] = (ld[k] && vsrc[k]) ? dsrc[k] : data_q[k];
      end
      cnt_d = cnt_q + 16'(out_valid && out_ready);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         mode_q <= '0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         mode_q <= mode_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end
   assign in_ready  = ld[0];
   assign out_valid = vld_q[PIPE-1];
   assign out_mode  = mode_q[PIPE-1];
   assign out_data  = data_q[PIPE-1];
   assign xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_sbox_lanes.sv
// tb_sbox_lanes: random and directed checks of sbox_lanes against a GF(2^8) reference model.
module tb_sbox_lanes;
   logic clk, rst_n;
   logic v0, ir0, m0, ov0, r0, om0;
   logic [31:0] d0, od0;
   logic [15:0] x0;
   logic v1, ir1, m1, ov1, r1, om1;
   logic [15:0] d1, od1, x1;
   int n_vec = 0, n_bad = 0;
   logic [7:0] fwd_t [256];
   logic [7:0] inv_t [256];
   logic [32:0] q0 [$];
   logic [16:0] q1 [$];
   logic [31:0] cap_q [$];
   logic [31:0] orig [256];
   logic [31:0] fw [256];
   int cnt0, cnt1, stall;
   logic hold0, hold1, cap_en, stall_en, done0, done1;
   logic [31:0] last_d0, tmp;
   logic [15:0] last_d1;
   logic last_m0, last_m1;
   logic [32:0] e0;
   logic [16:0] e1;

   sbox_lanes #(.LANES(4), .PIPE(2), .INV_EN(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(ir0), .in_mode(m0), .in_data(d0),
      .out_valid(ov0), .out_ready(r0), .out_data(od0), .out_mode(om0), .xfer_cnt(x0));
   sbox_lanes #(.LANES(2), .PIPE(3), .INV_EN(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1), .in_mode(m1), .in_data(d1),
      .out_valid(ov1), .out_ready(r1), .out_data(od1), .out_mode(om1), .xfer_cnt(x1));

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      n_vec++;
      n_bad++;
      $display("FAIL %s: event missing or unexpected", nm);
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [31:0] subst(input logic [31:0] d, input logic m);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = m ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         q0.delete(); q1.delete();
         cnt0 = 0; cnt1 = 0; hold0 = 0; hold1 = 0;
      end else begin
         if (hold0) chk("stable0", {ov0, om0, od0}, {1'b1, last_m0, last_d0});
         if (hold1) chk("stable1", {ov1, om1, od1}, {1'b1, last_m1, last_d1});
         if (ov0 && r0) begin
            if (q0.size() == 0) fail("unexpected_out0");
            else begin
               e0 = q0.pop_front();
               chk("data0", {om0, od0}, e0);
            end
            chk("cnt0", x0, cnt0[15:0]);
            cnt0++;
            if (cap_en) cap_q.push_back(od0);
         end
         if (ov1 && r1) begin
            if (q1.size() == 0) fail("unexpected_out1");
            else begin
               e1 = q1.pop_front();
               chk("data1", {om1, od1}, e1);
            end
            chk("cnt1", x1, cnt1[15:0]);
            cnt1++;
         end
         if (stall_en && v0 && !ir0) stall++;
         hold0 = ov0 && !r0; last_m0 = om0; last_d0 = od0;
         hold1 = ov1 && !r1; last_m1 = om1; last_d1 = od1;
         if (v0 && ir0) q0.push_back({m0, subst(d0, m0)});
         if (v1 && ir1) begin
            tmp = subst({16'h0, d1}, 1'b0);
            q1.push_back({1'b0, tmp[15:0]});
         end
      end
   end

   task automatic send(input int u, input logic m, input logic [31:0] d);
      int b = 0;
      if (u == 0) begin v0 = 1; m0 = m; d0 = d; end
      else begin v1 = 1; m1 = m; d1 = d[15:0]; end
      @(negedge clk);
      while (!(u == 0 ? ir0 : ir1) && b < 1000) begin @(negedge clk); b++; end
      if (b >= 1000) fail("accept_timeout");
      @(posedge clk); #1;
      if (u == 0) v0 = 0; else v1 = 0;
   endtask

   task automatic drain();
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int x = 0; x < 256; x++) begin
         logic [7:0] iv, r, s;
         iv = 0;
         for (int y = 1; y < 256; y++) if (gmul(x[7:0], y[7:0]) == 8'h01) iv = y[7:0];
         r = iv; s = iv;
         repeat (4) begin r = {r[6:0], r[7]}; s ^= r; end
         s ^= 8'h63;
         fwd_t[x] = s;
         inv_t[s] = x[7:0];
      end
      chk("pin_fwd00", fwd_t[8'h00], 8'h63);
      chk("pin_fwd01", fwd_t[8'h01], 8'h7c);
      chk("pin_fwd53", fwd_t[8'h53], 8'hed);
      chk("pin_fwdff", fwd_t[8'hff], 8'h16);
      chk("pin_inv00", inv_t[8'h00], 8'h52);
      cap_en = 0; stall_en = 0; stall = 0; done0 = 0; done1 = 0;
      rst_n = 0; v0 = 0; v1 = 0; m0 = 0; m1 = 0; d0 = 0; d1 = 0; r0 = 0; r1 = 0;
      repeat (2) @(negedge clk);
      chk("rst_valid0", ov0, 0);
      chk("rst_data0", od0, 0);
      chk("rst_mode0", om0, 0);
      chk("rst_cnt0", x0, 0);
      chk("rst_ready0", ir0, 1);
      chk("rst_ready1", ir1, 1);
      chk("rst_valid1", ov1, 0);
      @(posedge clk); #1; rst_n = 1;
      @(negedge clk);
      chk("ready_after_rst", ir0, 1);
      @(posedge clk); #1;
      r0 = 1; r1 = 1;
      send(0, 1'b0, 32'hFF53_0100);
      @(negedge clk); chk("lat_early0", ov0, 0);
      @(negedge clk); chk("fwd_valid", ov0, 1);
      chk("fwd_data", {om0, od0}, {1'b0, 32'h16ED_7C63});
      @(posedge clk); #1;
      send(0, 1'b1, 32'h16ED_7C63);
      @(negedge clk); @(negedge clk);
      chk("inv_data", {ov0, om0, od0}, {2'b11, 32'hFF53_0100});
      @(posedge clk); #1;
      send(1, 1'b1, 32'h0);
      @(negedge clk); @(negedge clk); chk("lat_early1", ov1, 0);
      @(negedge clk); chk("noinv_data", {ov1, om1, od1}, {2'b10, 16'h6363});
      @(posedge clk); #1;
      send(0, 1'b1, 32'h0);
      @(negedge clk); @(negedge clk);
      chk("inv_zero", {ov0, om0, od0}, {2'b11, 32'h5252_5252});
      drain();
      cap_q.delete(); cap_en = 1; stall = 0; stall_en = 1;
      for (int v = 0; v < 256; v++) begin
         logic [7:0] b;
         b = v[7:0];
         orig[v] = {b + 8'd192, b + 8'd128, b + 8'd64, b};
         send(0, 1'b0, orig[v]);
      end
      drain();
      chk("rt_fwd_count", cap_q.size(), 256);
      for (int v = 0; v < 256; v++) fw[v] = cap_q[v];
      cap_q.delete();
      for (int v = 0; v < 256; v++) send(0, 1'b1, fw[v]);
      drain();
      cap_en = 0; stall_en = 0;
      chk("rt_stalls", stall, 0);
      chk("rt_inv_count", cap_q.size(), 256);
      if (cap_q.size() == 256)
         for (int v = 0; v < 256; v++) chk("round_trip", cap_q[v], orig[v]);
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               send(0, 1'($urandom_range(0, 1)), $urandom);
            end
            done0 = 1;
         end
         begin
            for (int i = 0; i < 150; i++) begin
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               send(1, 1'($urandom_range(0, 1)), $urandom);
            end
            done1 = 1;
         end
         begin
            while (!(done0 && done1)) begin
               @(posedge clk); #1;
               r0 = ($urandom_range(0, 3) != 0);
               r1 = ($urandom_range(0, 2) != 0);
            end
            r0 = 1; r1 = 1;
         end
      join
      drain();
      r0 = 0;
      fork
         for (int i = 0; i < 6; i++) send(0, i[0], $urandom);
         begin
            repeat (5) @(negedge clk);
            chk("bp_ready_low", ir0, 0);
            chk("bp_out_valid", ov0, 1);
            @(posedge clk); #1; r0 = 1;
         end
      join
      drain();
      send(0, 1'b0, 32'h0102_0304);
      send(0, 1'b1, 32'h0506_0708);
      rst_n = 0;
      @(negedge clk);
      chk("mid_rst_valid", ov0, 0);
      chk("mid_rst_cnt", x0, 0);
      chk("mid_rst_data", {om0, od0}, 0);
      chk("mid_rst_ready", ir0, 1);
      @(posedge clk); #1; rst_n = 1;
      stall = 0;
      repeat (6) begin @(negedge clk); if (ov0 || ov1) stall++; end
      chk("post_rst_outputs", stall, 0);
      chk("post_rst_cnt", x0, 0);
      @(posedge clk); #1;
      for (int i = 0; i < 65537; i++) send(0, 1'($urandom_range(0, 1)), $urandom);
      drain();
      chk("cnt_wrap", x0, 16'h0001);
      chk("q0_empty", q0.size(), 0);
      chk("q1_empty", q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
